iomem_arbiter: RTL and testbench
================================

IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning slave-wait cycles before forced completion (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have ports: ck  in  1  single clock; all logic on posedge.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: m0_valid/m1_valid  in  1  master request, held until its ready.
REQ-005 SHALL have ports: m0_wstrb/m1_wstrb  in  4  byte strobes; 0 = read.
REQ-006 SHALL have ports: m0_addr/m1_addr, m0_wdata/m1_wdata  in  32  address, write data.
REQ-007 SHALL have ports: m0_ready/m1_ready  out  1  one-cycle completion to master.
REQ-008 SHALL have ports: m0_rdata/m1_rdata  out  32  read data, valid while its ready is high.
REQ-009 SHALL have ports: s_valid  out  1, s_wstrb  out  4, s_addr  out  32, s_wdata  out  32  shared slave port (audio engine iomem).
REQ-010 SHALL have ports: s_ready  in  1, s_rdata  in  32  slave completion, read data.
REQ-011 SHALL have ports: grant  out  2  one-hot owner (bit0 = m0, bit1 = m1), 0 when idle.
REQ-012 SHALL have ports: timeout_err  out  1  sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, BUSY0, BUSY1.
REQ-014 SHALL, in IDLE with any mX_valid, move to BUSY0/BUSY1 next edge, latching that master's wstrb/addr/wdata into s_* registers and setting s_valid=1 and grant.
REQ-015 SHALL resolve simultaneous requests round-robin: grant the master not served last; last_served resets to m1, so m0 wins the first tie.
REQ-016 SHALL drive mX_ready = s_ready && s_valid && grant[X] combinationally, and mX_rdata = s_rdata; the non-granted master sees ready=0, rdata=0.
REQ-017 SHALL, on the edge where s_ready&&s_valid, clear s_valid and grant, update last_served, and return to IDLE.
REQ-018 SHALL ignore s_ready while s_valid=0.
REQ-019 SHALL hold latched s_* fields constant throughout BUSY, even if the owning master drops valid or changes addr/wdata.
REQ-020 SHALL spend exactly one IDLE cycle between transactions (minimum 2 cycles from request to s_valid on back-to-back traffic).
REQ-021 SHALL, if m0 and m1 both request continuously, alternate grants m0,m1,m0,...; no master waits more than one transaction.
REQ-022 SHALL drive s_addr/s_wdata/s_wstrb to 0 whenever s_valid=0.

Reset
REQ-023 SHALL, on rst_n low (any time, including mid-transaction), immediately force state IDLE, s_valid=0, s_* fields=0, grant=0, m*_ready=0, last_served=m1, wait counter=0, timeout_err=0.
REQ-024 SHALL begin arbitration on the first posedge ck after rst_n deasserts.

Configuration
REQ-025 SHALL compile a slave-timeout watchdog when macro ARB_TIMEOUT_EN is defined.
REQ-026 SHALL, with ARB_TIMEOUT_EN, count BUSY cycles without s_ready; when count reaches TIMEOUT, assert granted mX_ready for one cycle with mX_rdata=32'hDEADBEEF, clear s_valid, set timeout_err=1 (sticky until reset), return to IDLE; s_ready in that same cycle takes precedence (normal completion, no error).
REQ-027 SHALL, without ARB_TIMEOUT_EN, wait indefinitely for s_ready and tie timeout_err to 0.

Verification
REQ-028 SHALL cover: m0 write addr 32'h60000000 data 32'h84000001, slave ready 1 cycle after s_valid -> s_* match, m0_ready one cycle, grant 01 then 00.
REQ-029 SHALL cover: m0 and m1 request same cycle after reset -> m0 served first, m1 second with exactly one IDLE cycle between.
REQ-030 SHALL cover: both request continuously for 6 transactions -> grant sequence 01,10,01,10,01,10.
REQ-031 SHALL cover: m1 read 32'h64000004, slave returns 32'h00001111 with s_ready -> m1_rdata=32'h00001111 while m1_ready, m0_rdata=0.
REQ-032 SHALL cover: rst_n low while BUSY1 with s_valid=1 -> s_valid, grant, m1_ready all 0 without waiting for ck; post-reset tie goes to m0.
REQ-033 SHALL cover (ARB_TIMEOUT_EN, TIMEOUT=16): slave never ready -> m0_ready after 16 BUSY cycles, rdata 32'hDEADBEEF, timeout_err=1 and remains 1 across later good transactions.

Source files
------------

// File: rtl/iomem_arbiter.sv
// -----------------------------------------------------------------------------
// iomem_arbiter
//
// Two-master to one-slave arbiter for the audio engine iomem port. Each master
// raises mX_valid and holds it until it sees mX_ready. The arbiter latches the
// winning master's request into the shared slave port and holds it there until
// the slave completes. Ties are broken round-robin, so the master that was not
// served last wins. Exactly one IDLE cycle separates consecutive transactions.
//
// Optional build macro:
//   ARB_TIMEOUT_EN - compiles a slave watchdog. After TIMEOUT busy cycles with
//                    no s_ready, the owning master is completed with
//                    rdata = 32'hDEADBEEF and the sticky timeout_err is set.
//                    Without the macro the arbiter waits forever for s_ready
//                    and timeout_err is tied to 0.
//
// Parameters:
//   TIMEOUT      slave-wait cycles before forced completion (watchdog only)
//
// Ports:
//   ck           clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   m0_* / m1_*  master request (valid, wstrb, addr, wdata); wstrb == 0 is a read
//   m0_ready / m1_ready   one-cycle completion back to each master
//   m0_rdata / m1_rdata   read data, s_rdata for the owner and 0 for the other
//   s_valid, s_wstrb, s_addr, s_wdata   shared slave request (0 while idle)
//   s_ready, s_rdata                    slave completion and read data
//   grant        one-hot owner, bit0 = m0, bit1 = m1, 0 when idle
//   timeout_err  sticky slave timeout flag
// -----------------------------------------------------------------------------
module iomem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        ck,
  input  logic        rst_n,

  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  // Which master completed most recently; 1 = m1. Resets to m1 so m0 wins the
  // first tie after reset.
  logic        last_m1_q, last_m1_d;

  logic        busy;
  logic        done;
  logic        timeout_fire;
  logic        complete;
  logic        pick_m1;
  logic [31:0] owner_rdata;

  // ---------------------------------------------------------------------------
  // Slave watchdog
  // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_q, wait_d;
  logic          timeout_err_q, timeout_err_d;

  // The forced completion happens in the cycle after TIMEOUT stalled cycles;
  // a slave that answers in that very cycle still wins.
  assign timeout_fire = busy && !s_ready && (wait_q == CW'(TIMEOUT));

  always_comb begin
    wait_d        = '0;
    timeout_err_d = timeout_err_q | timeout_fire;
    if (busy && !(done || timeout_fire)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      wait_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wait_q        <= wait_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // TIMEOUT only has meaning once the watchdog is compiled in.
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT);

  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration and transaction control
  // ---------------------------------------------------------------------------
  assign busy     = (state_q != IDLE);
  // s_ready is only meaningful while a request is outstanding.
  assign done     = busy && s_ready;
  assign complete = done || timeout_fire;
  // m1 wins when it is the only requester, or on a tie when m0 was served last.
  assign pick_m1  = m1_valid && (!m0_valid || !last_m1_q);

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    wstrb_d   = wstrb_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_m1_d = last_m1_q;

    unique case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          if (pick_m1) begin
            state_d = BUSY1;
            wstrb_d = m1_wstrb;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
          end else begin
            state_d = BUSY0;
            wstrb_d = m0_wstrb;
            addr_d  = m0_addr;
            wdata_d = m0_wdata;
          end
        end
      end

      BUSY0, BUSY1: begin
        // The latched fields stay frozen until completion regardless of what
        // the owning master does with its own inputs meanwhile.
        if (complete) begin
          state_d   = IDLE;
          wstrb_d   = '0;
          addr_d    = '0;
          wdata_d   = '0;
          last_m1_d = (state_q == BUSY1);
        end
      end

      default: begin
        state_d = IDLE;
        wstrb_d = '0;
        addr_d  = '0;
        wdata_d = '0;
      end
    endcase
  end

  // NOTE: the latched slave fields are reset along with the control state
  // because they drive the slave port directly and must read 0 the instant
  // reset asserts.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_m1_q <= 1'b1;
    end else begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values of the others.
      state_q   <= state_d;
      wstrb_q   <= wstrb_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_m1_q <= last_m1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_valid = busy;
  assign s_wstrb = wstrb_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

  assign grant   = {state_q == BUSY1, state_q == BUSY0};

  assign owner_rdata = timeout_fire ? TIMEOUT_RDATA : s_rdata;

  assign m0_ready = grant[0] && complete;
  assign m1_ready = grant[1] && complete;
  assign m0_rdata = grant[0] ? owner_rdata : 32'd0;
  assign m1_rdata = grant[1] ? owner_rdata : 32'd0;

endmodule

// File: tb/tb_iomem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iomem_arbiter
//
// Self-checking bench for iomem_arbiter. A transaction-level reference model
// (current owner, its latched request, who was served last, cycles waited)
// predicts every output each cycle; a compare process checks the DUT against it
// on the falling edge. Directed scenarios pin the model with literal values;
// a randomized phase then drives both masters and the slave with $urandom.
// -----------------------------------------------------------------------------
module tb_iomem_arbiter;

  localparam int TO = 16;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        m0_valid, m1_valid;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  iomem_arbiter #(.TIMEOUT(TO)) dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .m0_valid    (m0_valid),
    .m0_wstrb    (m0_wstrb),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_wstrb    (m1_wstrb),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_wstrb     (s_wstrb),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 ck = ~ck;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the slave and what request it is holding
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  int   owner;    // 0 = nobody, 1 = m0, 2 = m1
  int   last;     // master served most recently (1 or 2)
  int   waited;   // busy cycles so far without s_ready
  bit   err;
  req_t cur;

  function automatic bit model_timeout();
`ifdef ARB_TIMEOUT_EN
    return (owner != 0) && !s_ready && (waited == TO);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    owner     = 0;
    last      = 2;
    waited    = 0;
    err       = 1'b0;
    cur.wstrb = '0;
    cur.addr  = '0;
    cur.wdata = '0;
  endtask

  task automatic model_step();
    if (owner != 0) begin
      if (s_ready) begin
        last  = owner;
        owner = 0;
      end else if (model_timeout()) begin
        last  = owner;
        owner = 0;
        err   = 1'b1;
      end else begin
        waited++;
      end
    end else begin
      if (m0_valid && m1_valid) owner = (last == 1) ? 2 : 1;
      else if (m0_valid)        owner = 1;
      else if (m1_valid)        owner = 2;
      if (owner == 1) begin
        cur.wstrb = m0_wstrb; cur.addr = m0_addr; cur.wdata = m0_wdata;
      end else if (owner == 2) begin
        cur.wstrb = m1_wstrb; cur.addr = m1_addr; cur.wdata = m1_wdata;
      end
      waited = 0;
    end
  endtask

  initial model_reset();

  always @(posedge ck or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // ---------------------------------------------------------------------------
  logic m0_seen = 1'b0, m1_seen = 1'b0;

  always @(negedge ck) begin
    m0_seen = m0_ready;
    m1_seen = m1_ready;
    if (rst_n) begin
      automatic bit          fire  = (owner != 0) && (s_ready || model_timeout());
      automatic logic [31:0] ordat = model_timeout() ? 32'hDEADBEEF : s_rdata;
      check("cmp_s_valid", s_valid, owner != 0);
      check("cmp_grant",   grant,   (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
      check("cmp_s_addr",  s_addr,  (owner != 0) ? cur.addr  : 32'd0);
      check("cmp_s_wdata", s_wdata, (owner != 0) ? cur.wdata : 32'd0);
      check("cmp_s_wstrb", s_wstrb, (owner != 0) ? cur.wstrb : 4'd0);
      check("cmp_m0_ready", m0_ready, (owner == 1) && fire);
      check("cmp_m1_ready", m1_ready, (owner == 2) && fire);
      check("cmp_m0_rdata", m0_rdata, (owner == 1) ? ordat : 32'd0);
      check("cmp_m1_rdata", m1_rdata, (owner == 2) ? ordat : 32'd0);
      check("cmp_timeout_err", timeout_err, err);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
    s_ready  = 0; s_rdata  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge ck);
    @(negedge ck);
    #1 rst_n = 1'b1;
    cyc();
  endtask

  function automatic logic [3:0] rand_wstrb();
    return ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
  endfunction

  logic [1:0] rr_exp [12];

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_s_valid", s_valid, 1'b0);
    check("rst_grant",   grant,   2'b00);
    check("rst_m0_ready", m0_ready, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    repeat (2) @(posedge ck);
    @(negedge ck);
    #1 rst_n = 1'b1;
    cyc();

    // m0 write, slave answers one cycle after s_valid
    m0_valid = 1; m0_wstrb = 4'hF; m0_addr = 32'h6000_0000; m0_wdata = 32'h8400_0001;
    cyc();
    m0_addr = 32'h1234_5678; m0_wdata = 32'hCAFE_F00D;  // must not disturb latched fields
    #1;
    check("wr_s_valid", s_valid, 1'b1);
    check("wr_s_addr",  s_addr,  32'h6000_0000);
    check("wr_s_wdata", s_wdata, 32'h8400_0001);
    check("wr_s_wstrb", s_wstrb, 4'hF);
    check("wr_grant",   grant,   2'b01);
    check("wr_m0_ready_early", m0_ready, 1'b0);
    s_ready = 1;
    #1;
    check("wr_m0_ready", m0_ready, 1'b1);
    check("wr_m1_ready", m1_ready, 1'b0);
    cyc();
    m0_valid = 0; s_ready = 0;
    #1;
    check("wr_grant_after", grant, 2'b00);
    check("wr_s_valid_after", s_valid, 1'b0);
    check("wr_s_addr_after", s_addr, 32'd0);
    check("wr_m0_ready_after", m0_ready, 1'b0);
    cyc();

    // m1 read returning data
    m1_valid = 1; m1_wstrb = 4'h0; m1_addr = 32'h6400_0004; m1_wdata = 32'd0;
    cyc();
    check("rd_grant", grant, 2'b10);
    check("rd_s_wstrb", s_wstrb, 4'h0);
    s_rdata = 32'h0000_1111; s_ready = 1;
    #1;
    check("rd_m1_ready", m1_ready, 1'b1);
    check("rd_m1_rdata", m1_rdata, 32'h0000_1111);
    check("rd_m0_rdata", m0_rdata, 32'd0);
    check("rd_m0_ready", m0_ready, 1'b0);
    cyc();
    m1_valid = 0; s_ready = 0; s_rdata = '0;
    cyc();

    // simultaneous continuous requests after reset: m0 first, one idle between
    rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00,
               2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    do_reset();
    m0_valid = 1; m0_addr = 32'h6000_0010; m0_wdata = $urandom; m0_wstrb = 4'h3;
    m1_valid = 1; m1_addr = 32'h6400_0020; m1_wdata = $urandom; m1_wstrb = 4'h0;
    s_ready  = 1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check($sformatf("rr_grant_%0d", i), grant, rr_exp[i]);
    end
    m0_valid = 0; m1_valid = 0; s_ready = 0;
    cyc();

    // reset asserted mid-transaction while m1 owns the slave
    do_reset();
    m1_valid = 1; m1_addr = 32'h6400_0008; m1_wstrb = 4'h1; m1_wdata = 32'h55;
    cyc();
    check("mid_grant", grant, 2'b10);
    s_ready = 1;
    #1;
    check("mid_m1_ready_pre", m1_ready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_s_valid", s_valid, 1'b0);
    check("mid_grant_rst", grant, 2'b00);
    check("mid_m1_ready", m1_ready, 1'b0);
    check("mid_s_addr", s_addr, 32'd0);
    m0_valid = 1; m0_addr = 32'h6000_0004; m0_wstrb = 4'h0;
    s_ready = 0;
    @(negedge ck);
    #1 rst_n = 1'b1;
    cyc();
    check("mid_tie_m0", grant, 2'b01);
    m0_valid = 0; m1_valid = 0; s_ready = 1;
    cyc();
    s_ready = 0;
    cyc();

`ifdef ARB_TIMEOUT_EN
    // slave never answers: forced completion after TO busy cycles
    do_reset();
    m0_valid = 1; m0_wstrb = 4'h0; m0_addr = 32'h6000_0100;
    cyc();
    for (int i = 0; i < TO; i++) begin
      check($sformatf("to_wait_%0d", i), m0_ready, 1'b0);
      cyc();
    end
    check("to_m0_ready", m0_ready, 1'b1);
    check("to_m0_rdata", m0_rdata, 32'hDEADBEEF);
    m0_valid = 0;
    cyc();
    check("to_err_set", timeout_err, 1'b1);
    check("to_s_valid", s_valid, 1'b0);
    m1_valid = 1; m1_wstrb = 4'hF; m1_addr = 32'h6400_0000;
    cyc();
    s_ready = 1;
    #1;
    check("to_good_ready", m1_ready, 1'b1);
    cyc();
    m1_valid = 0; s_ready = 0;
    #1;
    check("to_err_sticky", timeout_err, 1'b1);
    cyc();
`else
    check("no_watchdog_err", timeout_err, 1'b0);
`endif

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m0_valid && m0_seen) begin
        m0_valid = 1'($urandom % 2);
        m0_wstrb = rand_wstrb(); m0_addr = $urandom; m0_wdata = $urandom;
      end else if (!m0_valid) begin
        if ($urandom % 3 == 0) begin
          m0_valid = 1;
          m0_wstrb = rand_wstrb(); m0_addr = $urandom; m0_wdata = $urandom;
        end
      end else if ($urandom % 4 == 0) begin
        m0_addr = $urandom; m0_wdata = $urandom;
      end

      if (m1_valid && m1_seen) begin
        m1_valid = 1'($urandom % 2);
        m1_wstrb = rand_wstrb(); m1_addr = $urandom; m1_wdata = $urandom;
      end else if (!m1_valid) begin
        if ($urandom % 3 == 0) begin
          m1_valid = 1;
          m1_wstrb = rand_wstrb(); m1_addr = $urandom; m1_wdata = $urandom;
        end
      end else if ($urandom % 4 == 0) begin
        m1_addr = $urandom; m1_wdata = $urandom;
      end

      s_ready = ($urandom % 4 == 0);
      s_rdata = $urandom;
      cyc();
    end

    idle_inputs();
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
